// File: rtl/vedic_mult6_seq.sv
// Sequential 6x6 unsigned multiplier that walks the four 3x3 partial products
// through a single Vedic 3x3 cell and shift-accumulates them into a 12-bit product.

module vedic3x3 (
    input  logic [2:0] A,
    input  logic [2:0] B,
    output logic [5:0] R
);
    logic [1:0] col1;
    logic [2:0] col2;
    logic [2:0] col3;
    logic [1:0] col4;

    // Urdhva-tiryagbhyam: sum each column of cross products plus the carry from the column below
    always_comb begin
        col1 = {1'b0, A[1] & B[0]} + {1'b0, A[0] & B[1]};
        col2 = {2'b0, A[2] & B[0]} + {2'b0, A[1] & B[1]} + {2'b0, A[0] & B[2]} + {2'b0, col1[1]};
        col3 = {2'b0, A[2] & B[1]} + {2'b0, A[1] & B[2]} + {1'b0, col2[2:1]};
        col4 = {1'b0, A[2] & B[2]} + col3[2:1];
        R    = {col4, col3[0], col2[0], col1[0], A[0] & B[0]};
    end
endmodule

module vedic_mult6_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  a,
    input  logic [5:0]  b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] p,
    output logic        out_valid,
    input  logic        out_ready
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [1:0]  step;
    logic [5:0]  a_r;
    logic [5:0]  b_r;
    logic [11:0] acc;
    logic [11:0] acc_sum;
    logic [2:0]  cell_a;
    logic [2:0]  cell_b;
    logic [5:0]  cell_r;

    // Place a 6-bit partial product at its weight: lo*lo at 0, cross terms at 3, hi*hi at 6
    function automatic logic [11:0] align_pp(input logic [5:0] r, input logic [1:0] s);
        case (s)
            2'd0:    align_pp = {6'b0, r};
            2'd3:    align_pp = {r, 6'b0};
            default: align_pp = {3'b0, r, 3'b0};
        endcase
    endfunction

    // step[0] selects the multiplicand half, step[1] the multiplier half
    always_comb begin
        cell_a  = step[0] ? a_r[5:3] : a_r[2:0];
        cell_b  = step[1] ? b_r[5:3] : b_r[2:0];
        acc_sum = acc + align_pp(cell_r, step);
    end

    vedic3x3 u_cell (
        .A (cell_a),
        .B (cell_b),
        .R (cell_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid) state_n = BUSY;
            BUSY:    if (step == 2'd3) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step <= 2'd0;
            acc  <= 12'd0;
            p    <= 12'd0;
            a_r  <= 6'd0;
            b_r  <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r  <= a;
                        b_r  <= b;
                        acc  <= 12'd0;
                        step <= 2'd0;
                    end
                end
                BUSY: begin
                    acc  <= acc_sum;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        p <= acc_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vedic_mult6_seq.sv
// Directed and scoreboarded bench for vedic_mult6_seq using immediate assertions.

module tb_vedic_mult6_seq;
    logic        clk;
    logic        rst;
    logic [5:0]  a;
    logic [5:0]  b;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] p;
    logic        out_valid;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    vedic_mult6_seq dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p         (p),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Full transaction with out_ready high: wait for in_ready, accept, expect result 4 edges later
    task automatic do_mult(input logic [5:0] x, input logic [5:0] y, input logic [11:0] expv, input string tag);
        int n;
        a = x;
        b = y;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, 32'd4);
        check({tag, "_p"}, {20'b0, p}, {20'b0, expv});
        tick();
        check({tag, "_taken"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [11:0] expq[$];
        logic [11:0] expv;
        int sent;
        int recv;
        int cyc;

        rst = 1'b1;
        a = 6'd0;
        b = 6'd0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_p", {20'b0, p}, 32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", {31'b0, in_ready}, 32'd1);

        // 45*27: in_ready low for exactly 5 cycles, result after 4
        a = 6'd45;
        b = 6'd27;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t1_busy_in_ready", {31'b0, in_ready}, 32'd0);
            check("t1_busy_out_valid", {31'b0, out_valid}, 32'd0);
            tick();
        end
        check("t1_out_valid", {31'b0, out_valid}, 32'd1);
        check("t1_p", {20'b0, p}, 32'd1215);
        check("t1_done_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        check("t1_after_out_valid", {31'b0, out_valid}, 32'd0);
        check("t1_after_in_ready", {31'b0, in_ready}, 32'd1);
        check("t1_p_hold", {20'b0, p}, 32'd1215);

        do_mult(6'd63, 6'd63, 12'd3969, "max");
        do_mult(6'd0, 6'd55, 12'd0, "zero");
        do_mult(6'd7, 6'd8, 12'd56, "7x8");
        do_mult(6'd1, 6'd1, 12'd1, "one");
        do_mult(6'd36, 6'd9, 12'd324, "36x9");

        // Backpressure: 38*51 held for 10 cycles
        tick();
        out_ready = 1'b0;
        a = 6'd38;
        b = 6'd51;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("bp_out_valid", {31'b0, out_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            check("bp_hold_p", {20'b0, p}, 32'd1938);
            check("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release", {31'b0, out_valid}, 32'd0);
        tick();
        check("bp_in_ready", {31'b0, in_ready}, 32'd1);

        // in_valid held with changing operands after accept
        a = 6'd12;
        b = 6'd10;
        in_valid = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            a = 6'(63 - i);
            b = 6'(50 + i);
            tick();
        end
        check("held_out_valid", {31'b0, out_valid}, 32'd1);
        check("held_p", {20'b0, p}, 32'd120);
        in_valid = 1'b0;
        tick();
        check("held_taken", {31'b0, out_valid}, 32'd0);

        // Reset while BUSY at step2
        a = 6'd33;
        b = 6'd44;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_p", {20'b0, p}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("midrst_no_result", {31'b0, out_valid}, 32'd0);
        end
        do_mult(6'd5, 6'd6, 12'd30, "post_rst");

        // Back-to-back random traffic against an in-order scoreboard
        sent = 0;
        recv = 0;
        cyc = 0;
        a = 6'($urandom_range(0, 63));
        b = 6'($urandom_range(0, 63));
        in_valid = 1'b1;
        while (recv < 200 && cyc < 5000) begin
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                expv = (expq.size() > 0) ? expq.pop_front() : 12'hFFF;
                check("rand_p", {20'b0, p}, {20'b0, expv});
                recv++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(12'(a) * 12'(b));
                sent++;
            end
            tick();
            if (sent >= 200) begin
                in_valid = 1'b0;
            end else if (in_valid && dut.state != 2'd0) begin
                a = 6'($urandom_range(0, 63));
                b = 6'($urandom_range(0, 63));
            end
            cyc++;
        end
        check("rand_recv", recv, 32'd200);
        check("rand_sent", sent, 32'd200);
        check("rand_leftover", expq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vedic_mult6_seq.md
Name: vedic_mult6_seq

Overview:
- Sequential 6x6 unsigned multiplier built on the team's existing combinational 3x3 multiplier cell (ports A[2:0], B[2:0], R[5:0]).
- Acts as the cell's upstream feeder and downstream consumer. It splits each operand into 3-bit halves, drives the cell with one half-pair per cycle, and shift-accumulates the four 6-bit partial products into a 12-bit result.
- Valid/ready handshakes on both input and output.

Parameters:
- None. Operand width is fixed at 6 and chunk width at 3 by the cell.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- a  input  6  multiplicand, unsigned
- b  input  6  multiplier, unsigned
- in_valid  input  1  a/b valid
- in_ready  output  1  block can accept operands
- p  output  12  product a*b, unsigned
- out_valid  output  1  p valid
- out_ready  input  1  consumer accepts p

Behaviour:
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0, step counter 0..3.
  - DONE: in_ready=0, out_valid=1.
- Reset (rst high at a clock edge):
  - state=IDLE, step=0, acc=0, p=0, out_valid=0, a_r=0, b_r=0.
  - in_ready is forced to 0 while rst is high.
  - Reset wins over every other event, including mid-BUSY and mid-DONE. Any in-flight result is discarded and no out_valid is produced.
- Accept: at an edge with state=IDLE and in_valid=1.
  - Capture a_r=a, b_r=b, acc=0, step=0, then go to BUSY.
  - in_valid while not IDLE is ignored; operands are not captured.
- BUSY, one cell evaluation per cycle. Cell inputs are muxed from a_r/b_r:
  - step0: A=a_r[2:0], B=b_r[2:0], acc += R
  - step1: A=a_r[5:3], B=b_r[2:0], acc += R<<3
  - step2: A=a_r[2:0], B=b_r[5:3], acc += R<<3
  - step3: A=a_r[5:3], B=b_r[5:3], acc += R<<6; also load p = acc+(R<<6), then go to DONE.
- Width rules:
  - acc is 12 bits; all adds are zero-extended to 12 bits.
  - Maximum result is 63*63=3969, so no overflow can occur and no carry-out is kept.
- Latency:
  - Accept at edge k; BUSY occupies edges k+1..k+4.
  - out_valid=1 and p are valid after edge k+4, so 4 cycles from accept to result.
- DONE:
  - p and out_valid are held stable until an edge with out_ready=1.
  - At that edge: out_valid->0 and go to IDLE. p retains its last value; it is only updated at step3.
  - in_ready rises the cycle after the result is taken. Throughput is 1 product per 6 cycles with out_ready held high.
- out_ready outside DONE has no effect.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid/out_ready to in_ready/out_valid.

Test Plan:
- Reset, then a=45, b=27, in_valid pulse, out_ready=1:
  - in_ready drops for exactly 5 cycles.
  - out_valid rises 4 cycles after accept with p=1215 (0x4BF).
  - in_ready returns 1 cycle later.
- Corner operands, each followed by a result check:
  - a=63, b=63 -> p=3969 (0xF81)
  - a=0, b=55 -> p=0
  - a=7, b=8 -> p=56
  - a=1, b=1 -> p=1
- Output backpressure: a=38, b=51 with out_ready=0 for 10 cycles.
  - p=1938 and out_valid stay stable for all 10 cycles; in_ready stays 0.
  - Raising out_ready completes the transfer in one cycle.
- Input held: in_valid held high with changing a/b during BUSY.
  - Only the operands present at the accept edge are used, e.g. accepted a=12, b=10 gives p=120 regardless of later values.
- Reset mid-operation: assert rst at BUSY step2.
  - Next cycle: state IDLE, out_valid=0, p=0.
  - A new a=5, b=6 then yields p=30 with normal latency.
- Randomised back-to-back: 200 random pairs with random out_ready.
  - Every p equals a*b in order, with no drops or duplicates.
